char_word_packer: RTL

- Parametrised successor to the single-width character capture path.
- Accepts a stream of CHAR_W-bit plotter characters over a valid/ready handshake and packs them, zero-extended to LANE_W bits, into CHARS_PER_WORD-lane words.
- Writes packed words to an external synchronous word RAM. On end-of-text it flushes any partial word, then switches to read mode, where characters are fetched back by character index with fixed latency.
- Adds handshake, overflow, out-of-range and restart behaviour that the previous generation lacked.

---
 rtl/char_word_packer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/char_word_packer.sv
// char_word_packer: packs a valid/ready stream of narrow characters into
// multi-lane words in an external synchronous RAM. On end-of-text it flushes
// any partial word and then serves indexed character reads back out of the RAM.
//
// Ports:
//   clk, reset (async, active high)
//   char_valid/char_data/char_ready : input character handshake
//   end_of_text : finish the fill (FILL), or restart from empty (READ)
//   rd_req/rd_index -> rd_valid/rd_char/rd_oob : indexed read, 2-cycle latency
//   mem_addr/mem_wdata/mem_wren/mem_rdata : word RAM, 1-cycle read latency
//   char_count/read_mode/overflow : status
module char_word_packer #(
  parameter int CHAR_W         = 6,
  parameter int LANE_W         = 8,
  parameter int CHARS_PER_WORD = 4,
  parameter int ADDR_W         = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic char_valid,
  input  logic [CHAR_W-1:0] char_data,
  output logic char_ready,
  input  logic end_of_text,
  input  logic rd_req,
  input  logic [ADDR_W+$clog2(CHARS_PER_WORD)-1:0] rd_index,
  output logic rd_valid,
  output logic [LANE_W-1:0] rd_char,
  output logic rd_oob,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANE_W*CHARS_PER_WORD-1:0] mem_wdata,
  output logic mem_wren,
  input  logic [LANE_W*CHARS_PER_WORD-1:0] mem_rdata,
  output logic [ADDR_W+$clog2(CHARS_PER_WORD):0] char_count,
  output logic read_mode,
  output logic overflow
);

  localparam int LB     = $clog2(CHARS_PER_WORD);
  localparam int IDX_W  = ADDR_W + LB;
  localparam int CNT_W  = IDX_W + 1;
  localparam int WORD_W = LANE_W * CHARS_PER_WORD;
  localparam logic [LB-1:0] LAST_LANE = LB'(CHARS_PER_WORD - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FLUSH = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  buf_q, buf_d;
  logic [WORD_W-1:0]  wword_q, wword_d;
  logic               pend_q, pend_d;
  logic [LB-1:0]      lane_q, lane_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic               full_q, full_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               s1_valid_q, s1_valid_d;
  logic [LB-1:0]      s1_lane_q, s1_lane_d;
  logic               s1_oob_q, s1_oob_d;
  logic               rd_valid_q, rd_valid_d;
  logic [LANE_W-1:0]  rd_char_q, rd_char_d;
  logic               rd_oob_q, rd_oob_d;

  logic               full_now;
  logic               accept;
  logic               flush_wr;
  logic [LANE_W-1:0]  lane_sel;

  // A full-word write to the last address in flight already counts as full,
  // so no character is accepted into a word that could never be written.
  assign full_now = full_q | (pend_q & (wptr_q == '1));
  assign accept   = (state_q == FILL) & char_valid & ~full_now;
  assign flush_wr = (state_q == FLUSH) & (pend_q | (lane_q != '0));

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    wword_d = wword_q;
    pend_d  = 1'b0;
    lane_d  = lane_q;
    wptr_d  = wptr_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      FILL: begin
        if (pend_q) begin
          wptr_d = wptr_q + ADDR_W'(1);
          if (wptr_q == '1) full_d = 1'b1;
        end
        if (char_valid & full_now) ovf_d = 1'b1;
        if (accept) begin
          buf_d[lane_q*LANE_W +: LANE_W] = LANE_W'(char_data);
          lane_d = lane_q + LB'(1);
          cnt_d  = cnt_q + CNT_W'(1);
          // Hand the completed word to the write slot so the buffer
          // is free for a back-to-back character next cycle.
          if (lane_q == LAST_LANE) begin
            pend_d  = 1'b1;
            wword_d = buf_d;
            buf_d   = '0;
          end
        end
        if (end_of_text) state_d = FLUSH;
      end
      FLUSH: begin
        if (flush_wr) begin
          wptr_d = wptr_q + ADDR_W'(1);
          if (wptr_q == '1) full_d = 1'b1;
          buf_d  = '0;
          lane_d = '0;
        end
        state_d = READ;
      end
      READ: begin
        if (end_of_text) begin
          buf_d   = '0;
          lane_d  = '0;
          wptr_d  = '0;
          full_d  = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    s1_valid_d = (state_q == READ) & rd_req;
    s1_lane_d  = rd_index[LB-1:0];
    s1_oob_d   = {1'b0, rd_index} >= cnt_q;
    lane_sel   = mem_rdata[s1_lane_q*LANE_W +: LANE_W];
    rd_valid_d = s1_valid_q;
    rd_oob_d   = s1_valid_q & s1_oob_q;
    rd_char_d  = (s1_valid_q & ~s1_oob_q) ? lane_sel : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FILL;
      buf_q      <= '0;
      wword_q    <= '0;
      pend_q     <= 1'b0;
      lane_q     <= '0;
      wptr_q     <= '0;
      full_q     <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_lane_q  <= '0;
      s1_oob_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_char_q  <= '0;
      rd_oob_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      wword_q    <= wword_d;
      pend_q     <= pend_d;
      lane_q     <= lane_d;
      wptr_q     <= wptr_d;
      full_q     <= full_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      s1_valid_q <= s1_valid_d;
      s1_lane_q  <= s1_lane_d;
      s1_oob_q   <= s1_oob_d;
      rd_valid_q <= rd_valid_d;
      rd_char_q  <= rd_char_d;
      rd_oob_q   <= rd_oob_d;
    end
  end

  assign char_ready = (state_q == FILL) & ~full_now & ~reset;
  assign mem_wren   = ((state_q == FILL) & pend_q) | flush_wr;
  assign mem_wdata  = pend_q ? wword_q : buf_q;
  assign mem_addr   = (state_q == READ)
                    ? (rd_req ? rd_index[IDX_W-1:LB] : '0)
                    : wptr_q;
  assign rd_valid   = rd_valid_q;
  assign rd_char    = rd_char_q;
  assign rd_oob     = rd_oob_q;
  assign char_count = cnt_q;
  assign read_mode  = (state_q == READ);
  assign overflow   = ovf_q;

endmodule
